// File: rtl/pi_2ch_seq.sv
// Two-axis PI regulator sharing one signed multiplier, sequenced X then Y per SAMPLE.
// Define PI_INT_SAT_EN to saturate integrator updates; otherwise integrators wrap modulo 2^32.
module pi_2ch_seq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic                             CLOCK,
  input  logic                             RESET_N,
  input  logic                             SAMPLE,
  input  logic signed [DATA_W-1:0]         ERR_X,
  input  logic signed [DATA_W-1:0]         ERR_Y,
  input  logic signed [COEF_W-1:0]         KP,
  input  logic signed [COEF_W-1:0]         KI,
  input  logic                             CLR_INT,
  output logic signed [DATA_W+COEF_W-1:0]  DATA_OUT,
  output logic                             AXIS_SEL,
  output logic                             ENABLE,
  output logic                             BUSY,
  output logic                             OVERRUN
);

  localparam int ACC_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, MULP_X, MULI_X, ACC_X, OUT_X, MULP_Y, MULI_Y, ACC_Y, OUT_Y
  } state_t;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1])
      return sum[ACC_W] ? ACC_MIN : ACC_MAX;
    return sum[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] int_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
`ifdef PI_INT_SAT_EN
    return sat_add(a, b);
`else
    return a + b;
`endif
  endfunction

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] err_x_p0, err_y_p0;
  logic signed [COEF_W-1:0] kp_p0, ki_p0;
  logic signed [ACC_W-1:0]  p_p1, q_p1;
  logic signed [ACC_W-1:0]  i_x, i_y;
  logic signed [ACC_W-1:0]  data_out_q;
  logic                     axis_sel_q;
  logic                     overrun_q;

  logic                     axis_y, is_mulp, acc_en, capture_en, busy_c, enable_c;
  logic signed [ACC_W-1:0]  coef_ext, err_ext, prod;
  logic signed [ACC_W-1:0]  i_cur, i_sum, i_new, s_new;

  // State register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = SAMPLE ? MULP_X : IDLE;
      MULP_X:  state_d = MULI_X;
      MULI_X:  state_d = ACC_X;
      ACC_X:   state_d = OUT_X;
      OUT_X:   state_d = MULP_Y;
      MULP_Y:  state_d = MULI_Y;
      MULI_Y:  state_d = ACC_Y;
      ACC_Y:   state_d = OUT_Y;
      OUT_Y:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    busy_c     = (state_q != IDLE);
    enable_c   = (state_q == OUT_X) || (state_q == OUT_Y);
    axis_y     = (state_q == MULP_Y) || (state_q == MULI_Y) || (state_q == ACC_Y)
              || (state_q == OUT_Y);
    is_mulp    = (state_q == MULP_X) || (state_q == MULP_Y);
    acc_en     = (state_q == ACC_X) || (state_q == ACC_Y);
    capture_en = (state_q == IDLE) && SAMPLE;
  end

  // Shared multiplier: KP in MULP states, KI in MULI states
  assign coef_ext = {{DATA_W{(is_mulp ? kp_p0[COEF_W-1] : ki_p0[COEF_W-1])}},
                     (is_mulp ? kp_p0 : ki_p0)};
  assign err_ext  = axis_y ? {{COEF_W{err_y_p0[DATA_W-1]}}, err_y_p0}
                           : {{COEF_W{err_x_p0[DATA_W-1]}}, err_x_p0};
  assign prod     = coef_ext * err_ext;

  // Clear overrides the accumulate so the sum reduces to P alone
  assign i_cur = axis_y ? i_y : i_x;
  assign i_sum = int_add(i_cur, q_p1);
  assign i_new = CLR_INT ? '0 : i_sum;
  assign s_new = sat_add(p_p1, i_new);

  // p0: operand capture; p1: products; integrators and output register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_x_p0   <= '0;
      err_y_p0   <= '0;
      kp_p0      <= '0;
      ki_p0      <= '0;
      p_p1       <= '0;
      q_p1       <= '0;
      i_x        <= '0;
      i_y        <= '0;
      data_out_q <= '0;
      axis_sel_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (capture_en) begin
        err_x_p0 <= ERR_X;
        err_y_p0 <= ERR_Y;
        kp_p0    <= KP;
        ki_p0    <= KI;
      end
      if (is_mulp) p_p1 <= prod;
      if ((state_q == MULI_X) || (state_q == MULI_Y)) q_p1 <= prod;
      if (CLR_INT) begin
        i_x <= '0;
        i_y <= '0;
      end else if (acc_en) begin
        if (axis_y) i_y <= i_sum;
        else        i_x <= i_sum;
      end
      if (acc_en) begin
        data_out_q <= s_new;
        axis_sel_q <= axis_y;
      end
      overrun_q <= SAMPLE && busy_c;
    end
  end

  assign DATA_OUT = data_out_q;
  assign AXIS_SEL = axis_sel_q;
  assign ENABLE   = enable_c;
  assign BUSY     = busy_c;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_pi_2ch_seq.sv
// Directed self-checking bench for pi_2ch_seq (expected values hand-computed).
module tb_pi_2ch_seq;

  logic               CLOCK = 1'b0;
  logic               RESET_N = 1'b0;
  logic               SAMPLE = 1'b0;
  logic               CLR_INT = 1'b0;
  logic signed [15:0] ERR_X = '0, ERR_Y = '0, KP = '0, KI = '0;
  logic signed [31:0] DATA_OUT;
  logic               AXIS_SEL, ENABLE, BUSY, OVERRUN;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

  pi_2ch_seq dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .SAMPLE   (SAMPLE),
    .ERR_X    (ERR_X),
    .ERR_Y    (ERR_Y),
    .KP       (KP),
    .KI       (KI),
    .CLR_INT  (CLR_INT),
    .DATA_OUT (DATA_OUT),
    .AXIS_SEL (AXIS_SEL),
    .ENABLE   (ENABLE),
    .BUSY     (BUSY),
    .OVERRUN  (OVERRUN)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Launches one sequence (SAMPLE at edge N) and checks cycles N+1..N+9.
  // clr0: CLR_INT together with SAMPLE; clr_k / s1 / s2: edge N+k to pulse CLR_INT / SAMPLE (0 = none).
  task automatic drive_sequence(input string name,
                                input logic signed [15:0] ex, ey, kp, ki,
                                input bit clr0, input int clr_k, input int s1, input int s2,
                                input logic signed [31:0] exp_x, exp_y);
    ERR_X = ex; ERR_Y = ey; KP = kp; KI = ki;
    SAMPLE = 1'b1; CLR_INT = clr0;
    @(posedge CLOCK); #1;
    SAMPLE = 1'b0; CLR_INT = 1'b0;
    ERR_X = 16'sh1234; ERR_Y = -16'sh0777; KP = 16'sh0101; KI = -16'sh0202;
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (BUSY !== (k <= 8)) begin
        failures++;
        $display("FAIL %s busy N+%0d: got %b want %b", name, k, BUSY, (k <= 8));
      end
      checks++;
      if (ENABLE !== (k == 4 || k == 8)) begin
        failures++;
        $display("FAIL %s enable N+%0d: got %b want %b", name, k, ENABLE, (k == 4 || k == 8));
      end
      checks++;
      if (OVERRUN !== (k > 1 && ((k - 1) == s1 || (k - 1) == s2))) begin
        failures++;
        $display("FAIL %s overrun N+%0d: got %b", name, k, OVERRUN);
      end
      if (k == 4 || k == 6) begin
        checks++;
        if (DATA_OUT !== exp_x || AXIS_SEL !== 1'b0) begin
          failures++;
          $display("FAIL %s x N+%0d: got %0d/%h sel %b want %0d/%h sel 0",
                   name, k, DATA_OUT, DATA_OUT, AXIS_SEL, exp_x, exp_x);
        end
      end
      if (k == 8 || k == 9) begin
        checks++;
        if (DATA_OUT !== exp_y || AXIS_SEL !== 1'b1) begin
          failures++;
          $display("FAIL %s y N+%0d: got %0d/%h sel %b want %0d/%h sel 1",
                   name, k, DATA_OUT, DATA_OUT, AXIS_SEL, exp_y, exp_y);
        end
      end
      SAMPLE = (k == s1 || k == s2);
      CLR_INT = (k == clr_k);
      @(posedge CLOCK); #1;
      SAMPLE = 1'b0; CLR_INT = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    CLR_INT = 1'b1;
    @(posedge CLOCK); #1;
    CLR_INT = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    SAMPLE = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++;
    if (DATA_OUT !== 32'sd0 || AXIS_SEL !== 1'b0 || ENABLE !== 1'b0 ||
        BUSY !== 1'b0 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: data %h sel %b en %b busy %b ovr %b want all 0",
               DATA_OUT, AXIS_SEL, ENABLE, BUSY, OVERRUN);
    end
    SAMPLE = 1'b0;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK); #1;
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset idle: busy %b want 0", BUSY);
    end
  endtask

  task automatic test_basic();
    drive_sequence("basic", 16'sd100, -16'sd50, 16'sd2, 16'sd1, 1'b0, 0, 0, 0, 32'sd300, -32'sd150);
  endtask

  task automatic test_accumulate();
    drive_sequence("accum", 16'sd100, -16'sd50, 16'sd2, 16'sd1, 1'b0, 0, 0, 0, 32'sd400, -32'sd200);
  endtask

  task automatic test_clear();
    pulse_clr();
    drive_sequence("clr_idle", 16'sd100, -16'sd50, 16'sd2, 16'sd1, 1'b0, 0, 0, 0, 32'sd300, -32'sd150);
    drive_sequence("clr_with_sample", 16'sd100, -16'sd50, 16'sd2, 16'sd1, 1'b1, 0, 0, 0, 32'sd300, -32'sd150);
  endtask

  task automatic test_clear_in_acc();
    // Clear at ACC_X: X = P only, Y integrator cleared then accumulates -50.
    drive_sequence("clr_acc", 16'sd100, -16'sd50, 16'sd2, 16'sd1, 1'b0, 3, 0, 0, 32'sd200, -32'sd150);
    drive_sequence("after_clr_acc", 16'sd100, -16'sd50, 16'sd2, 16'sd1, 1'b0, 0, 0, 0, 32'sd300, -32'sd200);
  endtask

  task automatic test_overrun();
    drive_sequence("overrun", 16'sd100, -16'sd50, 16'sd2, 16'sd1, 1'b0, 0, 3, 8, 32'sd400, -32'sd250);
    checks++;
    if (BUSY !== 1'b0 || ENABLE !== 1'b0) begin
      failures++;
      $display("FAIL overrun dropped: busy %b en %b want 0 0", BUSY, ENABLE);
    end
  endtask

  task automatic test_out_sat();
    pulse_clr();
    drive_sequence("out_sat1", 16'sh7FFF, -16'sd32768, 16'sh7FFF, 16'sh7FFF, 1'b0, 0, 0, 0,
                   32'sh7FFE0002, 32'sh80010000);
    drive_sequence("out_sat2", 16'sh7FFF, -16'sd32768, 16'sh7FFF, 16'sh7FFF, 1'b0, 0, 0, 0,
                   32'sh7FFFFFFF, 32'sh80000000);
  endtask

  task automatic test_int_sat();
    logic signed [31:0] exp3;
`ifdef PI_INT_SAT_EN
    exp3 = 32'sh7FFFFFFF;
`else
    exp3 = 32'shBFFD0003;
`endif
    pulse_clr();
    drive_sequence("int1", 16'sh7FFF, 16'sd0, 16'sd0, 16'sh7FFF, 1'b0, 0, 0, 0, 32'sh3FFF0001, 32'sd0);
    drive_sequence("int2", 16'sh7FFF, 16'sd0, 16'sd0, 16'sh7FFF, 1'b0, 0, 0, 0, 32'sh7FFE0002, 32'sd0);
    drive_sequence("int3", 16'sh7FFF, 16'sd0, 16'sd0, 16'sh7FFF, 1'b0, 0, 0, 0, exp3, 32'sd0);
  endtask

  task automatic test_reset_mid_seq();
    ERR_X = 16'sd10; ERR_Y = 16'sd20; KP = 16'sd3; KI = 16'sd1;
    SAMPLE = 1'b1;
    @(posedge CLOCK); #1;
    SAMPLE = 1'b0;
    repeat (5) begin
      @(posedge CLOCK); #1;
    end
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL midrst pre busy: got %b want 1", BUSY);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (DATA_OUT !== 32'sd0 || AXIS_SEL !== 1'b0 || ENABLE !== 1'b0 ||
        BUSY !== 1'b0 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL midrst outputs: data %h sel %b en %b busy %b ovr %b want all 0",
               DATA_OUT, AXIS_SEL, ENABLE, BUSY, OVERRUN);
    end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLOCK); #1;
      checks++;
      if (ENABLE !== 1'b0 || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL midrst after c%0d: en %b busy %b want 0 0", c, ENABLE, BUSY);
      end
    end
    drive_sequence("midrst_next", 16'sd10, 16'sd20, 16'sd3, 16'sd1, 1'b0, 0, 0, 0, 32'sd40, 32'sd80);
  endtask

  task automatic test_min_product();
    drive_sequence("min_prod", -16'sd32768, 16'sd5, -16'sd32768, 16'sd0, 1'b1, 0, 0, 0,
                   32'sh40000000, -32'sd163840);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_clear();
    test_clear_in_acc();
    test_overrun();
    test_out_sat();
    test_int_sat();
    test_reset_mid_seq();
    test_min_product();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pi_2ch_seq.md
PI_2CH_SEQ -- requirements
Module: pi_2ch_seq

Interface
REQ-001 SHALL have ports: CLOCK  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: RESET_N  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: SAMPLE  in  1  one-cycle strobe, new error pair valid.
REQ-004 SHALL have ports: ERR_X, ERR_Y  in  16 each  signed axis errors.
REQ-005 SHALL have ports: KP, KI  in  16 each  signed gains, shared by both axes.
REQ-006 SHALL have ports: CLR_INT  in  1  synchronous clear of both integrators.
REQ-007 SHALL have ports: DATA_OUT  out  32  signed regulator result, time-multiplexed X/Y.
REQ-008 SHALL have ports: AXIS_SEL  out  1  0 = DATA_OUT is X, 1 = Y.
REQ-009 SHALL have ports: ENABLE  out  1  one-cycle write strobe to downstream X/Y latch.
REQ-010 SHALL have ports: BUSY  out  1  sequence in progress.
REQ-011 SHALL have ports: OVERRUN  out  1  one-cycle pulse, SAMPLE dropped.

Function
REQ-012 SHALL run FSM IDLE -> MULP_X -> MULI_X -> ACC_X -> OUT_X -> MULP_Y -> MULI_Y -> ACC_Y -> OUT_Y -> IDLE, one state per cycle.
REQ-013 SHALL leave IDLE only when SAMPLE=1 in IDLE, capturing ERR_X, ERR_Y, KP, KI on that edge; captured values hold for the whole sequence.
REQ-014 SHALL use one shared 16x16 signed multiplier: MULP_a registers P=KP*err_a, MULI_a registers Q=KI*err_a (32-bit full products).
REQ-015 SHALL in ACC_a update integrator I_a <= I_a + Q (32-bit signed) and register S = P + I_a(new), saturated to 0x7FFFFFFF / 0x80000000.
REQ-016 SHALL in OUT_a drive DATA_OUT=S, AXIS_SEL=a, ENABLE=1 from registers; ENABLE=0 in all other states.
REQ-017 SHALL, with SAMPLE sampled at edge N, assert ENABLE with AXIS_SEL=0 in cycle N+4 and with AXIS_SEL=1 in cycle N+8; BUSY=1 cycles N+1..N+8.
REQ-018 SHALL hold DATA_OUT and AXIS_SEL at last driven values outside OUT states.
REQ-019 SHALL ignore SAMPLE when BUSY=1 and pulse OVERRUN for one cycle; SAMPLE in cycle N+8 (OUT_Y) also counts as overrun.
REQ-020 SHALL zero I_X and I_Y at any edge with CLR_INT=1; if coincident with ACC_a, clear wins and S = P (saturated) for that axis.
REQ-021 SHALL, on CLR_INT with SAMPLE in IDLE, clear integrators and accept the sample.
REQ-022 SHALL keep I_X and I_Y across sequences; no other state persists.

Reset
REQ-023 SHALL on RESET_N=0, asynchronously, force FSM=IDLE, I_X=I_Y=0, DATA_OUT=0, AXIS_SEL=0, ENABLE=0, BUSY=0, OVERRUN=0, capture registers=0.
REQ-024 SHALL on reset mid-sequence abandon it with no ENABLE pulse; first SAMPLE after RESET_N rises is accepted normally.

Configuration
REQ-025 SHALL, with PI_INT_SAT_EN defined, saturate the integrator update of REQ-015 to 0x7FFFFFFF / 0x80000000 on signed overflow.
REQ-026 SHALL, without PI_INT_SAT_EN, let the integrator wrap modulo 2^32; output-sum saturation of REQ-015 applies in both builds.

Verification
REQ-027 SHALL cover: reset, KP=2, KI=1, ERR_X=100, ERR_Y=-50, SAMPLE -> ENABLE at N+4 DATA_OUT=300 AXIS_SEL=0, at N+8 DATA_OUT=-150 AXIS_SEL=1.
REQ-028 SHALL cover: repeat same SAMPLE -> X=400, Y=-200 (integrators 200/-100); then CLR_INT, SAMPLE -> X=300, Y=-150.
REQ-029 SHALL cover: SAMPLE at N+3 and N+8 of a sequence -> both dropped, OVERRUN pulses each, exactly two ENABLE pulses.
REQ-030 SHALL cover: KP=0, KI=0x7FFF, ERR_X=0x7FFF, 3 samples -> with PI_INT_SAT_EN DATA_OUT X=0x7FFFFFFF on third; without, I_X wraps negative, DATA_OUT=0x7FFFFFFF only via output saturation where sum overflows, else wrapped integrator value.
REQ-031 SHALL cover: RESET_N low at N+6 -> no Y ENABLE, all outputs 0, next SAMPLE yields X=KP*e+KI*e from zero integrators.
REQ-032 SHALL cover: KP=-32768, ERR_X=-32768, KI=0 -> DATA_OUT=0x40000000, no saturation.
